framebuffer_responder: RTL and testbench
========================================

FRAMEBUFFER_RESPONDER -- requirements
Module: framebuffer_responder

Interface
REQ-001 Parameter WIDTH, default 320, pixel columns.
REQ-002 Parameter HEIGHT, default 200, pixel rows.
REQ-003 Derived constants: WORDS_PER_ROW = WIDTH/8; WORDS = WORDS_PER_ROW*HEIGHT (8000 at default); WIDTH SHALL be a multiple of 8.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ram_x  input  9  pixel column of the pixel-port request.
REQ-007 ram_y  input  8  pixel row of the pixel-port request.
REQ-008 op_ram_enable_read  input  1  pixel read request, this cycle.
REQ-009 op_ram_enable_write  input  1  pixel write request, this cycle.
REQ-010 op_ram_write_value  input  1  bit value to write.
REQ-011 op_ram_value  output  1  read bit, one cycle after the request.
REQ-012 scan_enable  input  1  scanout byte read request.
REQ-013 scan_addr  input  13  scanout word address (row*WORDS_PER_ROW + column/8).
REQ-014 scan_byte  output  8  scanout data; bit k = pixel column 8*(scan_addr mod WORDS_PER_ROW)+k.
REQ-015 fb_busy  output  1  high while the reset clear sweep runs.
REQ-016 range_error  output  1  one-cycle pulse on an out-of-range pixel request.

Function
REQ-017 Storage: WORDS bytes, one bit per pixel; word = ram_y*WORDS_PER_ROW + ram_x[8:3]; bit = ram_x[2:0].
REQ-018 Pixel port is single-cycle issue, no handshake: a new request may arrive every cycle, back-to-back, to any address.
REQ-019 Read: request in cycle t -> op_ram_value carries the addressed bit in cycle t+1; held until the next read result.
REQ-020 Write: executed as read-modify-write: byte read in cycle t, merged byte written at the end of cycle t+1; only the addressed bit changes.
REQ-021 Read and write both asserted: write performed; op_ram_value in t+1 returns the bit's pre-write value.
REQ-022 Hazard forwarding: the last written word address and byte are registered; if a request in cycle t targets that word, its old byte comes from the forward register, not memory; consecutive writes to bits of one word therefore all survive.
REQ-023 Read in cycle t+1 of a word written by a request in cycle t returns the new value.
REQ-024 Range: ram_x >= WIDTH or ram_y >= HEIGHT -> no memory change, op_ram_value = 0 in t+1, range_error = 1 in t+1.
REQ-025 Scanout port: independent second read port; scan_enable in cycle t -> scan_byte valid in t+1, held otherwise; a pixel-port write completing at the end of cycle t is visible to scanout reads issued in t+1 or later.
REQ-026 scan_addr >= WORDS -> scan_byte = 0.
REQ-027 States: CLEAR, RUN.
REQ-028 CLEAR: writes 0x00 to one word per cycle, addresses 0..WORDS-1 ascending; fb_busy = 1; pixel and scanout requests ignored (op_ram_value = 0, scan_byte = 0, range_error = 0); after word WORDS-1 -> RUN.
REQ-029 RUN: fb_busy = 0; services requests per REQ-018..026.
REQ-030 Forward register invalidated on entry to RUN.

Reset
REQ-031 rst high at a clock edge -> state CLEAR, clear counter 0, forward register invalid, pipeline stage empty (in-flight write discarded), op_ram_value = 0, scan_byte = 0, range_error = 0, fb_busy = 1 from the next cycle.
REQ-032 rst asserted mid-sweep or mid-RMW restarts the sweep from word 0.
REQ-033 fb_busy deasserts exactly WORDS cycles after rst deasserts; first serviced request is in that cycle.

Verification
REQ-034 Reset then count -> fb_busy high for exactly 8000 cycles; afterwards scan every word -> all 0x00.
REQ-035 Write 1 to pixels x=0..7, y=0 in 8 consecutive cycles -> scan word 0 reads 0xFF; read x=3,y=0 -> op_ram_value 1 one cycle later.
REQ-036 Write 1 to (5,10) in cycle t, read (5,10) in t+1 -> op_ram_value 1 in t+2; read (4,10) -> 0.
REQ-037 Read+write (12,3) value 1 on a cleared pixel -> op_ram_value 0 next cycle; subsequent read -> 1.
REQ-038 Write (320,0) and (0,200) -> range_error pulses each, scan words 0 and 7999 unchanged; scan_addr 8000 -> scan_byte 0x00.
REQ-039 Pulse rst during a write burst at word 100 -> sweep restarts, fb_busy 8000 cycles, word 100 reads 0x00.

Source files
------------

// File: rtl/framebuffer_responder.sv
`default_nettype none
// ============================================================================
// framebuffer_responder: 1-bpp framebuffer, RMW pixel port + scanout port
// Rev 1.0
// ============================================================================
module framebuffer_responder #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] ram_x,
    input  logic [7:0] ram_y,
    input  logic       op_ram_enable_read,
    input  logic       op_ram_enable_write,
    input  logic       op_ram_write_value,
    output logic       op_ram_value,
    input  logic       scan_enable,
    input  logic [12:0] scan_addr,
    output logic [7:0] scan_byte,
    output logic       fb_busy,
    output logic       range_error
);

    localparam int WORDS_PER_ROW = WIDTH / 8;
    localparam int WORDS         = WORDS_PER_ROW * HEIGHT;
    localparam int AW            = 13;
    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
    localparam logic [AW:0]   WORDS_EXT = (AW + 1)'(WORDS);

    if ((WIDTH % 8) != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of 8");
    end

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_cnt;
    logic [7:0]      mem [0:WORDS-1];

    // Request decode (cycle t)
    logic            req_valid;
    logic            req_in_range;
    logic [AW-1:0]   req_word;
    logic            scan_in_range;

    // Pipeline stage holding the request issued in the previous cycle
    logic            p_valid;
    logic            p_read;
    logic            p_write;
    logic            p_wval;
    logic            p_in_range;
    logic [2:0]      p_bit;
    logic [AW-1:0]   p_word;
    logic [7:0]      rd_raw;

    logic            fwd_valid;
    logic [AW-1:0]   fwd_word;
    logic [7:0]      fwd_byte;

    logic [7:0]      old_byte;
    logic [7:0]      merged;
    logic            rmw_we;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [7:0]      mem_wdata;
    logic            read_result;
    logic            held_value;
    logic [7:0]      scan_raw;
    logic            scan_ok;

    assign req_valid     = (state == ST_RUN) && (op_ram_enable_read || op_ram_enable_write);
    assign req_in_range  = (16'(ram_x) < 16'(WIDTH)) && (16'(ram_y) < 16'(HEIGHT));
    assign req_word      = AW'(ram_y) * AW'(WORDS_PER_ROW) + AW'(ram_x[8:3]);
    assign scan_in_range = ({1'b0, scan_addr} < WORDS_EXT);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fb_busy    = 1'b0;
        case (state)
            ST_CLEAR: begin
                fb_busy = 1'b1;
                if (clr_cnt == LAST_WORD) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                fb_busy = 1'b0;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read-modify-write datapath
    // ------------------------------------------------------------------------
    always_comb begin
        // The word written at the previous edge is not yet visible in rd_raw.
        old_byte = (fwd_valid && (fwd_word == p_word)) ? fwd_byte : rd_raw;
        merged         = old_byte;
        merged[p_bit]  = p_wval;
        rmw_we         = p_valid && p_write && p_in_range;
        mem_we         = 1'b0;
        mem_waddr      = p_word;
        mem_wdata      = merged;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = 8'h00;
            end else begin
                mem_we    = rmw_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (req_valid && req_in_range) begin
            rd_raw <= mem[req_word];
        end
        if (scan_enable && (state == ST_RUN) && scan_in_range) begin
            scan_raw <= mem[scan_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt    <= '0;
            p_valid    <= 1'b0;
            p_read     <= 1'b0;
            p_write    <= 1'b0;
            p_wval     <= 1'b0;
            p_in_range <= 1'b0;
            p_bit      <= 3'd0;
            p_word     <= '0;
            fwd_valid  <= 1'b0;
            fwd_word   <= '0;
            fwd_byte   <= 8'h00;
            held_value <= 1'b0;
            scan_ok    <= 1'b0;
        end else begin
            clr_cnt    <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
            p_valid    <= req_valid;
            p_read     <= op_ram_enable_read;
            p_write    <= op_ram_enable_write;
            p_wval     <= op_ram_write_value;
            p_in_range <= req_in_range;
            p_bit      <= ram_x[2:0];
            p_word     <= req_word;
            held_value <= op_ram_value;
            if (state == ST_CLEAR) begin
                fwd_valid <= 1'b0;
            end else if (rmw_we) begin
                fwd_valid <= 1'b1;
                fwd_word  <= p_word;
                fwd_byte  <= merged;
            end
            if (state == ST_CLEAR) begin
                scan_ok <= 1'b0;
            end else if (scan_enable) begin
                scan_ok <= scan_in_range;
            end
        end
    end

    // Out-of-range requests always produce a zero read result.
    assign read_result  = p_valid && (p_read || !p_in_range);
    assign op_ram_value = read_result ? (p_in_range & old_byte[p_bit]) : held_value;
    assign range_error  = p_valid && !p_in_range;
    assign scan_byte    = scan_ok ? scan_raw : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_responder.sv
`default_nettype none
// Directed table-driven bench for framebuffer_responder.
module tb_framebuffer_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  ram_x;
    logic [7:0]  ram_y;
    logic        op_ram_enable_read;
    logic        op_ram_enable_write;
    logic        op_ram_write_value;
    logic        op_ram_value;
    logic        scan_enable;
    logic [12:0] scan_addr;
    logic [7:0]  scan_byte;
    logic        fb_busy;
    logic        range_error;

    framebuffer_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .ram_x               (ram_x),
        .ram_y               (ram_y),
        .op_ram_enable_read  (op_ram_enable_read),
        .op_ram_enable_write (op_ram_enable_write),
        .op_ram_write_value  (op_ram_write_value),
        .op_ram_value        (op_ram_value),
        .scan_enable         (scan_enable),
        .scan_addr           (scan_addr),
        .scan_byte           (scan_byte),
        .fb_busy             (fb_busy),
        .range_error         (range_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic       rd;
        logic       wr;
        logic       val;
        logic       exp_val;
        logic       exp_re;
    } vec_t;

    vec_t vecs [0:25];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(input int x, input int y, input bit rd, input bit wr,
                                input bit val, input bit ev, input bit er);
        vec_t v;
        v.x = 9'(x); v.y = 8'(y); v.rd = rd; v.wr = wr; v.val = val;
        v.exp_val = ev; v.exp_re = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle;
        op_ram_enable_read  = 1'b0;
        op_ram_enable_write = 1'b0;
        op_ram_write_value  = 1'b0;
        ram_x               = 9'd0;
        ram_y               = 8'd0;
        scan_enable         = 1'b0;
        scan_addr           = 13'd0;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Counts busy cycles while hammering both ports; nothing may be serviced.
    task automatic count_sweep(input string tag);
        int n    = 0;
        int errs = 0;
        op_ram_enable_read  = 1'b1;
        op_ram_enable_write = 1'b1;
        op_ram_write_value  = 1'b1;
        ram_x               = 9'd400;
        ram_y               = 8'd0;
        scan_enable         = 1'b1;
        scan_addr           = 13'd0;
        while (fb_busy === 1'b1 && n < 9000) begin
            if (range_error !== 1'b0 || scan_byte !== 8'h00 || op_ram_value !== 1'b0) errs++;
            n++;
            if (n == 7990) idle();
            @(posedge clk); #1;
        end
        idle();
        chk({tag, "_busy_cycles"}, 32'(n), 32'd8000);
        chk({tag, "_ignored"}, 32'(errs), 32'd0);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ram_x               = vecs[i].x;
            ram_y               = vecs[i].y;
            op_ram_enable_read  = vecs[i].rd;
            op_ram_enable_write = vecs[i].wr;
            op_ram_write_value  = vecs[i].val;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_value", i), 32'(op_ram_value), 32'(vecs[i].exp_val));
            chk($sformatf("vec%0d_range", i), 32'(range_error), 32'(vecs[i].exp_re));
        end
        idle();
    endtask

    task automatic scan_chk(input string name, input int addr, input logic [7:0] exp);
        scan_enable = 1'b1;
        scan_addr   = 13'(addr);
        @(posedge clk); #1;
        scan_enable = 1'b0;
        chk(name, 32'(scan_byte), 32'(exp));
    endtask

    initial begin
        // x, y, rd, wr, val, expected value, expected range_error
        for (int k = 0; k < 8; k++) vecs[k] = mk(k, 0, 0, 1, 1, 0, 0);
        vecs[8]  = mk(3,   0,   1, 0, 0, 1, 0);
        vecs[9]  = mk(5,   10,  0, 1, 1, 1, 0);
        vecs[10] = mk(5,   10,  1, 0, 0, 1, 0);
        vecs[11] = mk(4,   10,  1, 0, 0, 0, 0);
        vecs[12] = mk(12,  3,   1, 1, 1, 0, 0);
        vecs[13] = mk(12,  3,   1, 0, 0, 1, 0);
        vecs[14] = mk(320, 0,   0, 1, 1, 0, 1);
        vecs[15] = mk(0,   200, 0, 1, 1, 0, 1);
        vecs[16] = mk(319, 199, 1, 0, 0, 0, 0);
        vecs[17] = mk(319, 199, 0, 1, 1, 0, 0);
        vecs[18] = mk(319, 199, 1, 1, 0, 1, 0);
        vecs[19] = mk(319, 199, 1, 0, 0, 0, 0);
        vecs[20] = mk(400, 0,   1, 0, 0, 0, 1);
        vecs[21] = mk(2,   0,   1, 0, 0, 1, 0);
        vecs[22] = mk(2,   0,   0, 1, 0, 1, 0);
        vecs[23] = mk(2,   0,   1, 0, 0, 0, 0);
        vecs[24] = mk(1,   0,   1, 0, 0, 1, 0);
        vecs[25] = mk(0,   255, 1, 0, 0, 0, 1);

        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy",  32'(fb_busy),      32'd1);
        chk("rst_value", 32'(op_ram_value), 32'd0);
        chk("rst_scan",  32'(scan_byte),    32'd0);
        chk("rst_range", 32'(range_error),  32'd0);
        count_sweep("sweep0");

        begin
            int bad = 0;
            for (int i = 0; i < 8000; i++) begin
                scan_enable = 1'b1;
                scan_addr   = 13'(i);
                @(posedge clk); #1;
                if (scan_byte !== 8'h00) bad++;
            end
            idle();
            chk("scan_all_zero", 32'(bad), 32'd0);
        end

        run_vectors(0, 8);
        scan_chk("scan_word0_ff", 0, 8'hFF);
        run_vectors(9, 25);

        scan_chk("scan_word0",    0,    8'hFB);
        scan_chk("scan_word40",   40,   8'h00);
        scan_chk("scan_word7999", 7999, 8'h00);
        scan_chk("scan_word121",  121,  8'h10);
        scan_chk("scan_word400",  400,  8'h20);
        scan_addr = 13'd0;
        @(posedge clk); #1;
        chk("scan_hold", 32'(scan_byte), 32'h20);
        scan_chk("scan_addr8000", 8000, 8'h00);
        scan_chk("scan_addr8191", 8191, 8'h00);

        // Write completing at an edge is seen only by scans issued after it.
        ram_x = 9'd8; ram_y = 8'd0;
        op_ram_enable_write = 1'b1; op_ram_write_value = 1'b1;
        scan_enable = 1'b1; scan_addr = 13'd1;
        @(posedge clk); #1;
        op_ram_enable_write = 1'b0;
        chk("scan_pre_write", 32'(scan_byte), 32'h00);
        @(posedge clk); #1;
        chk("scan_same_edge", 32'(scan_byte), 32'h00);
        @(posedge clk); #1;
        chk("scan_after_write", 32'(scan_byte), 32'h01);
        idle();

        // Reset in the middle of a write burst to word 100.
        for (int k = 0; k < 4; k++) begin
            ram_x = 9'(160 + k); ram_y = 8'd2;
            op_ram_enable_write = 1'b1; op_ram_write_value = 1'b1;
            if (k == 3) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle();
        count_sweep("sweep1");
        scan_chk("scan_word100", 100, 8'h00);

        // Reset partway through a sweep restarts it from word 0.
        repeat (3000) @(posedge clk);
        #1;
        pulse_rst();
        count_sweep("sweep2");
        scan_chk("scan_word0_cleared", 0, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
